fetch_unit: RTL and testbench

- Instruction fetch stage for the pipelined MIPS core.
- Owns the PC and issues instruction-memory reads.
- Holds each fetched word in an output register and hands it to decode (the control unit's opcode/funct source) over a valid/ready handshake.
- Takes PC redirects for branches and jumps, and stops fetching once a HALT instruction has been accepted by decode.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage for the pipelined MIPS core. Owns the PC, issues
//   instruction-memory reads, and holds each fetched word in an output
//   register that decode consumes over a valid/ready handshake. Downstream
//   redirects (taken branches, jumps) flush the output register and reload
//   the PC. Once decode accepts a HALT instruction, fetching stops until reset.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   iREN         instruction-memory read enable
//   imemaddr     instruction-memory address (the PC register)
//   ihit         memory returns imemload this cycle (only while iREN=1)
//   imemload     instruction word from memory
//   instr        registered instruction to decode
//   npc          address of instr plus 4
//   instr_valid  instr/npc hold a live instruction
//   dec_ready    decode accepts instr this cycle
//   redirect     flush and reload the PC from redirect_pc
//   redirect_pc  new PC, low two bits forced to zero
//   halted       sticky, set once a HALT instruction has been accepted
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] instr,
  output logic [31:0] npc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic slotFree;
  logic accept;
  logic acceptHalt;
  logic [31:0] pcPlus4;

  // The output register can take a new word when it is empty or when decode
  // is draining it in this same cycle (gives one instruction per cycle).
  assign slotFree   = !valid_q || dec_ready;
  assign accept     = valid_q && dec_ready;
  assign acceptHalt = accept && (instr_q[31:26] == HALT_OP);
  assign pcPlus4    = pc_q + 32'd4;

  // Read enable is the only output with a combinational path from the
  // handshake and redirect inputs; a redirect suppresses the read so the
  // stale address is never fetched.
  assign iREN = (state_q == FETCH) && slotFree && !redirect && !RST;

  assign imemaddr    = pc_q;
  assign instr       = instr_q;
  assign npc         = npc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

  // Next-state logic. Priority inside FETCH: redirect, then the HALT check
  // on an accepted instruction, then a memory hit, then a plain accept.
  // A hit arriving in the cycle a HALT is accepted is dropped so the PC
  // freezes at the address following the HALT.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc & 32'hFFFF_FFFC;
          valid_d = 1'b0;
        end else if (acceptHalt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else if (ihit && iREN) begin
          instr_d = imemload;
          npc_d   = pcPlus4;
          valid_d = 1'b1;
          pc_d    = pcPlus4;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      HALTED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State register; reset wins over everything, including the halted state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= 32'h0;
      npc_q    <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model of the fetch
//   stage (PC, output slot, halt flag) is advanced once per clock from the
//   same inputs and compared to every DUT output each cycle. Directed
//   sequences pin the model with literal expectations, then a long random
//   run exercises the handshake, redirects, halts and resets together.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        instr_valid;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model of the stage
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mNpc;
  logic        mValid;
  logic        mHalted;

  fetch_unit #(
    .PC_INIT(32'h00000000),
    .HALT_OP(6'b111111)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iREN       (iREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .instr      (instr),
    .npc        (npc),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halted     (halted)
  );

  // Free-running clock, period 10
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Recognisable word tagged with the address it was fetched from
  function automatic logic [31:0] tagWord(input logic [31:0] addr);
    return {6'b000000, addr[25:0]} ^ 32'h00A5_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Compare all outputs against the model, advance the model across one
  // rising edge using the current inputs, and return at the next falling edge.
  task automatic applyStimulus();
    logic        expRen;
    logic        slot;
    logic        nValid;
    logic        nHalted;
    logic [31:0] nPc;
    logic [31:0] nInstr;
    logic [31:0] nNpc;
    #1;
    slot   = !mValid || dec_ready;
    expRen = !RST && !mHalted && slot && !redirect;
    checkOutput("iREN", {31'b0, iREN}, {31'b0, expRen});
    checkOutput("imemaddr", imemaddr, mPc);
    checkOutput("instr", instr, mInstr);
    checkOutput("npc", npc, mNpc);
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, mValid});
    checkOutput("halted", {31'b0, halted}, {31'b0, mHalted});

    nPc = mPc; nInstr = mInstr; nNpc = mNpc; nValid = mValid; nHalted = mHalted;
    if (RST) begin
      nPc = 32'h0; nInstr = 32'h0; nNpc = 32'h0; nValid = 1'b0; nHalted = 1'b0;
    end else if (!mHalted) begin
      if (redirect) begin
        nPc    = {redirect_pc[31:2], 2'b00};
        nValid = 1'b0;
      end else if (mValid && dec_ready && mInstr[31:26] == 6'h3F) begin
        nHalted = 1'b1;
        nValid  = 1'b0;
      end else if (slot && ihit) begin
        nInstr = imemload;
        nNpc   = mPc + 32'd4;
        nPc    = mPc + 32'd4;
        nValid = 1'b1;
      end else if (mValid && dec_ready) begin
        nValid = 1'b0;
      end
    end
    @(posedge CLK);
    mPc = nPc; mInstr = nInstr; mNpc = nNpc; mValid = nValid; mHalted = nHalted;
    @(negedge CLK);
  endtask

  task automatic setInputs(input logic rst, input logic hit, input logic [31:0] load,
                           input logic rdy, input logic redir, input logic [31:0] rpc);
    RST = rst; ihit = hit; imemload = load; dec_ready = rdy;
    redirect = redir; redirect_pc = rpc;
  endtask

  initial begin
    mPc = 32'h0; mInstr = 32'h0; mNpc = 32'h0; mValid = 1'b0; mHalted = 1'b0;
    setInputs(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);

    // Reset for two cycles, iREN must stay low even with a ready decode
    setInputs(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    #1 checkOutput("rst_iren", {31'b0, iREN}, 32'd0);
    applyStimulus();
    checkOutput("rst_pc", imemaddr, 32'h0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);

    // Free run: one hit per cycle, decode always ready
    for (int i = 0; i < 4; i++) begin
      setInputs(1'b0, 1'b1, tagWord(imemaddr), 1'b1, 1'b0, 32'h0);
      #1 checkOutput("run_addr", imemaddr, 32'(i * 4));
      applyStimulus();
      if (i == 0) begin
        checkOutput("first_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("first_npc", npc, 32'h4);
        checkOutput("first_instr", instr, tagWord(32'h0));
      end
    end

    // Decode stall on an ADDU word
    setInputs(1'b0, 1'b1, 32'h0022_1820, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      setInputs(1'b0, 1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 32'h0);
      #1 checkOutput("stall_iren", {31'b0, iREN}, 32'd0);
      applyStimulus();
      checkOutput("stall_instr", instr, 32'h0022_1820);
      checkOutput("stall_pc", imemaddr, 32'h14);
      checkOutput("stall_npc", npc, 32'h14);
    end
    setInputs(1'b0, 1'b1, tagWord(32'h14), 1'b1, 1'b0, 32'h0);
    #1 checkOutput("resume_iren", {31'b0, iREN}, 32'd1);
    applyStimulus();
    checkOutput("resume_instr", instr, tagWord(32'h14));

    // Slow memory at PC=8
    setInputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8);
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      setInputs(1'b0, 1'b0, 32'hBAD0_0001, 1'b1, 1'b0, 32'h0);
      #1 checkOutput("slow_iren", {31'b0, iREN}, 32'd1);
      applyStimulus();
      checkOutput("slow_addr", imemaddr, 32'h8);
    end
    setInputs(1'b0, 1'b1, tagWord(32'h8), 1'b1, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("slow_pc", imemaddr, 32'hC);
    setInputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("slow_single", {31'b0, instr_valid}, 32'd0);

    // Redirect together with a hit: hit word must never appear
    setInputs(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0103);
    applyStimulus();
    checkOutput("redir_pc", imemaddr, 32'h100);
    checkOutput("redir_valid", {31'b0, instr_valid}, 32'd0);
    setInputs(1'b0, 1'b1, tagWord(32'h100), 1'b1, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("redir_instr", instr, tagWord(32'h100));

    // HALT accepted, then a redirect must be ignored
    setInputs(1'b0, 1'b1, 32'hFC00_0000, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    setInputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("halt_flag", {31'b0, halted}, 32'd1);
    setInputs(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h40);
    #1 checkOutput("halt_iren", {31'b0, iREN}, 32'd0);
    applyStimulus();
    checkOutput("halt_pc", imemaddr, 32'h108);

    // HALT accepted together with a redirect is flushed
    setInputs(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    setInputs(1'b0, 1'b1, 32'hFC00_0000, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    setInputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    applyStimulus();
    checkOutput("haltredir_flag", {31'b0, halted}, 32'd0);
    checkOutput("haltredir_pc", imemaddr, 32'h200);

    // PC wrap, then reset during an outstanding fetch
    setInputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus();
    setInputs(1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("wrap_pc", imemaddr, 32'h0);
    checkOutput("wrap_npc", npc, 32'h0);
    setInputs(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    setInputs(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus();
    checkOutput("midrst_pc", imemaddr, 32'h0);
    checkOutput("midrst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midrst_halted", {31'b0, halted}, 32'd0);

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] word;
      word = $urandom;
      if ($urandom_range(0, 19) == 0) word[31:26] = 6'h3F;
      setInputs($urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 6,
                word,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) == 0,
                $urandom);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
